// File: rtl/punc_loader_pkg.sv
// Shared definitions for the PUnC image loader: FSM states, byte-order
// constants for 16-bit fields, and small state-classification helpers.
package punc_loader_pkg;

  typedef enum logic [3:0] {
    ORG_HI = 4'd0,
    ORG_LO = 4'd1,
    CNT_HI = 4'd2,
    CNT_LO = 4'd3,
    DAT_HI = 4'd4,
    DAT_LO = 4'd5,
    WRITE  = 4'd6,
    CSUM   = 4'd7,
    DONE   = 4'd8,
    ERR    = 4'd9
  } state_t;

  // 16-bit fields (ORIGIN, COUNT, data words) arrive MSB first.
  localparam int unsigned WORD_HI_SHIFT = 8;
  localparam int unsigned WORD_LO_SHIFT = 0;

  // States in which the loader consumes an upstream byte.
  function automatic logic is_byte_state(input state_t s);
    logic r;
    case (s)
      ORG_HI, ORG_LO, CNT_HI, CNT_LO, DAT_HI, DAT_LO, CSUM: r = 1'b1;
      default:                                             r = 1'b0;
    endcase
    return r;
  endfunction

  // States whose byte is the high half of a 16-bit field.
  function automatic logic is_hi_state(input state_t s);
    logic r;
    case (s)
      ORG_HI, CNT_HI, DAT_HI: r = 1'b1;
      default:                r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/punc_loader_word_asm.sv
// Pairs MSB/LSB bytes into 16-bit words and keeps the running XOR of all
// accepted non-checksum bytes.
module punc_loader_word_asm
  import punc_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        take,
  input  logic        hi_sel,
  input  logic        csum_sel,
  input  logic [7:0]  din,
  output logic [15:0] pair,
  output logic [7:0]  xor_acc
);

  logic [7:0] hi_r;
  logic [7:0] xor_r;

  // Latch high bytes and fold every accepted non-checksum byte into the XOR.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_r  <= 8'h00;
      xor_r <= 8'h00;
    end else begin
      if (take && hi_sel) begin
        hi_r <= din;
      end
      if (take && !csum_sel) begin
        xor_r <= xor_r ^ din;
      end
    end
  end

  // The low byte is paired straight from the input so the word is usable on
  // the same edge that accepts it.
  assign pair    = (16'(hi_r) << WORD_HI_SHIFT) | (16'(din) << WORD_LO_SHIFT);
  assign xor_acc = xor_r;

endmodule

// File: rtl/punc_loader.sv
// PUnC boot loader: parses ORIGIN/COUNT/data/checksum byte stream, writes the
// data words into PUnC memory and releases the core once the image verifies.
module punc_loader
  import punc_loader_pkg::*;
#(
  parameter int MEM_DEPTH = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        core_hold,
  output logic        load_done,
  output logic        load_err
);

  state_t      state_r;
  state_t      state_nxt_s;
  logic [15:0] origin_r;
  logic [15:0] count_r;
  logic [15:0] index_r;
  logic [15:0] pair_s;
  logic [7:0]  xor_s;
  logic [16:0] end_s;
  logic [15:0] index_inc_s;
  logic        take_s;
  logic        in_ready_r;
  logic        mem_we_r;
  logic [15:0] mem_addr_r;
  logic [15:0] mem_wdata_r;
  logic        core_hold_r;
  logic        load_done_r;
  logic        load_err_r;

  assign take_s      = in_valid & in_ready_r;
  assign end_s       = {1'b0, origin_r} + {1'b0, pair_s};
  assign index_inc_s = index_r + 16'd1;

  punc_loader_word_asm u_word_asm (
    .clk      (clk),
    .rst      (rst),
    .take     (take_s),
    .hi_sel   (is_hi_state(state_r)),
    .csum_sel (state_r == CSUM),
    .din      (in_data),
    .pair     (pair_s),
    .xor_acc  (xor_s)
  );

  // Next-state decode; byte states only advance on an accepted byte.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ORG_HI: if (take_s) state_nxt_s = ORG_LO; else state_nxt_s = ORG_HI;
      ORG_LO: if (take_s) state_nxt_s = CNT_HI; else state_nxt_s = ORG_LO;
      CNT_HI: if (take_s) state_nxt_s = CNT_LO; else state_nxt_s = CNT_HI;
      CNT_LO: begin
        if (!take_s) begin
          state_nxt_s = CNT_LO;
        end else if (end_s > 17'(MEM_DEPTH)) begin
          state_nxt_s = ERR;
        end else if (pair_s == 16'h0000) begin
          state_nxt_s = CSUM;
        end else begin
          state_nxt_s = DAT_HI;
        end
      end
      DAT_HI: if (take_s) state_nxt_s = DAT_LO; else state_nxt_s = DAT_HI;
      DAT_LO: if (take_s) state_nxt_s = WRITE;  else state_nxt_s = DAT_LO;
      WRITE:  if (index_inc_s < count_r) state_nxt_s = DAT_HI; else state_nxt_s = CSUM;
      CSUM: begin
        if (!take_s) begin
          state_nxt_s = CSUM;
        end else if (in_data == xor_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = ERR;
        end
      end
      DONE:    state_nxt_s = DONE;
      ERR:     state_nxt_s = ERR;
      default: state_nxt_s = ERR;
    endcase
  end

  // State register, registered outputs derived from the next state, and the
  // ORIGIN/COUNT/index/write-port datapath.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ORG_HI;
      origin_r    <= 16'h0000;
      count_r     <= 16'h0000;
      index_r     <= 16'h0000;
      in_ready_r  <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 16'h0000;
      mem_wdata_r <= 16'h0000;
      core_hold_r <= 1'b1;
      load_done_r <= 1'b0;
      load_err_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= is_byte_state(state_nxt_s);
      mem_we_r    <= (state_nxt_s == WRITE);
      core_hold_r <= (state_nxt_s != DONE);
      load_done_r <= (state_nxt_s == DONE);
      load_err_r  <= (state_nxt_s == ERR);
      if (state_r == ORG_LO && take_s) begin
        origin_r <= pair_s;
      end
      if (state_r == CNT_LO && take_s) begin
        count_r <= pair_s;
      end
      if (state_r == DAT_LO && take_s) begin
        mem_addr_r  <= origin_r + index_r;
        mem_wdata_r <= pair_s;
      end
      if (state_r == WRITE) begin
        index_r <= index_inc_s;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign core_hold = core_hold_r;
  assign load_done = load_done_r;
  assign load_err  = load_err_r;

endmodule

// File: tb/tb_punc_loader.sv
// Self-checking bench for punc_loader: table of directed images, a mid-load
// reset sequence, and randomized images with random in_valid gaps, all
// compared against a parse-level reference model.
module tb_punc_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        core_hold;
  logic        load_done;
  logic        load_err;

  always #5 clk = ~clk;

  punc_loader #(.MEM_DEPTH(128)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .core_hold (core_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    logic [95:0] b;        // stream bytes MSB first, checksum excluded
    int          len;
    bit          bad_csum;
    int          gap;      // -1 = random 0..5
    bit          exp_done;
    bit          exp_err;
    int          exp_writes;
  } vec_t;

  int         n_checks = 0;
  int         n_errors = 0;
  wr_t        log_q[$];
  wr_t        exp_q[$];
  wr_t        prev_q[$];
  logic [7:0] stim_q[$];
  int         m_consumed;
  bit         m_done;
  vec_t       tbl[10];

  // Record every memory write strobe seen on the DUT port.
  always @(negedge clk) begin
    if (rst === 1'b1 && mem_we === 1'b1) log_q.push_back({mem_addr, mem_wdata});
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: interpret stim_q by the format rules.
  task automatic model();
    int origin, count, idx;
    logic [7:0] x;
    exp_q.delete();
    origin = {stim_q[0], stim_q[1]};
    count  = {stim_q[2], stim_q[3]};
    if (origin + count > 128) begin
      m_consumed = 4;
      m_done     = 1'b0;
    end else begin
      for (int i = 0; i < count; i++) begin
        wr_t w;
        w.addr = 16'(origin + i);
        w.data = {stim_q[4 + 2*i], stim_q[5 + 2*i]};
        exp_q.push_back(w);
      end
      x = 8'h00;
      for (int i = 0; i < 4 + 2*count; i++) x = x ^ stim_q[i];
      idx        = 4 + 2*count;
      m_consumed = idx + 1;
      m_done     = (stim_q[idx] == x);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    ok = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 50 && !ok; t++) begin
      if (in_ready === 1'b1) begin
        @(posedge clk);
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    chk("byte_accept", 32'(ok), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);
    log_q.delete();
  endtask

  // Load stim_q (optionally after a reset), then check against the model,
  // including that a terminal state ignores further in_valid.
  task automatic load(input bit with_rst, input int gap_mode);
    int nw;
    if (with_rst) do_reset();
    model();
    for (int i = 0; i < m_consumed; i++) begin
      send_byte(stim_q[i], (gap_mode < 0) ? int'($urandom_range(0, 5)) : gap_mode);
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("n_writes", 32'(log_q.size()), 32'(exp_q.size()));
    if (log_q.size() == exp_q.size()) begin
      for (int i = 0; i < log_q.size(); i++) begin
        chk("wr_addr", 32'(log_q[i].addr), 32'(exp_q[i].addr));
        chk("wr_data", 32'(log_q[i].data), 32'(exp_q[i].data));
      end
    end
    chk("load_done", 32'(load_done), 32'(m_done));
    chk("load_err",  32'(load_err),  32'(!m_done));
    chk("core_hold", 32'(core_hold), 32'(!m_done));
    chk("in_ready_term", 32'(in_ready), 32'd0);
    nw = log_q.size();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("term_no_write", 32'(log_q.size()), 32'(nw));
    chk("term_done_hold", 32'(load_done), 32'(m_done));
    chk("term_err_hold",  32'(load_err),  32'(!m_done));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
    chk({tag, "_mem_we"},    32'(mem_we),    32'd0);
    chk({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, "_core_hold"}, 32'(core_hold), 32'd1);
    chk({tag, "_load_done"}, 32'(load_done), 32'd0);
    chk({tag, "_load_err"},  32'(load_err),  32'd0);
  endtask

  initial begin
    logic [7:0] x;
    int origin, count;

    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #1 rst = 1'b0;
    #10;
    check_reset_outputs("reset");

    tbl[0] = '{96'h0010_0002_1234_ABCD_0000_0000, 8, 1'b0,  0, 1'b1, 1'b0, 2};
    tbl[1] = '{96'h0010_0002_1234_ABCD_0000_0000, 8, 1'b0,  3, 1'b1, 1'b0, 2};
    tbl[2] = '{96'h007F_0002_1234_ABCD_0000_0000, 8, 1'b0,  0, 1'b0, 1'b1, 0};
    tbl[3] = '{96'h0000_0000_0000_0000_0000_0000, 4, 1'b0,  0, 1'b1, 1'b0, 0};
    tbl[4] = '{96'h0000_0000_0000_0000_0000_0000, 4, 1'b1,  0, 1'b0, 1'b1, 0};
    tbl[5] = '{96'h0010_0002_1234_ABCD_0000_0000, 8, 1'b1,  0, 1'b0, 1'b1, 2};
    tbl[6] = '{96'h007E_0002_1122_3344_0000_0000, 8, 1'b0, -1, 1'b1, 1'b0, 2};
    tbl[7] = '{96'h0080_0000_0000_0000_0000_0000, 4, 1'b0,  0, 1'b1, 1'b0, 0};
    tbl[8] = '{96'h0080_0001_5566_0000_0000_0000, 6, 1'b0,  0, 1'b0, 1'b1, 0};
    tbl[9] = '{96'h0000_0001_FFFF_0000_0000_0000, 6, 1'b0,  5, 1'b1, 1'b0, 1};

    // Table-driven directed images.
    for (int v = 0; v < 10; v++) begin
      stim_q.delete();
      x = 8'h00;
      for (int i = 0; i < tbl[v].len; i++) begin
        stim_q.push_back(tbl[v].b[95 - 8*i -: 8]);
        x = x ^ tbl[v].b[95 - 8*i -: 8];
      end
      stim_q.push_back(tbl[v].bad_csum ? (x ^ 8'h01) : x);
      load(1'b1, tbl[v].gap);
      chk("tbl_done",   32'(load_done),    32'(tbl[v].exp_done));
      chk("tbl_err",    32'(load_err),     32'(tbl[v].exp_err));
      chk("tbl_writes", 32'(log_q.size()), 32'(tbl[v].exp_writes));
    end

    // Reset between DAT_HI and DAT_LO of word 1, then a fresh image.
    do_reset();
    send_byte(8'h00, 0); send_byte(8'h10, 0); send_byte(8'h00, 0);
    send_byte(8'h02, 0); send_byte(8'h12, 0); send_byte(8'h34, 0);
    send_byte(8'hAB, 0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (3) @(negedge clk);
    chk("midrst_n_writes", 32'(log_q.size()), 32'd1);
    if (log_q.size() == 1) begin
      chk("midrst_w0", 32'({log_q[0].addr, log_q[0].data}), 32'h0010_1234);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    log_q.delete();
    stim_q = '{8'h00, 8'h20, 8'h00, 8'h01, 8'hBE, 8'hEF, 8'h20 ^ 8'h01 ^ 8'hBE ^ 8'hEF};
    load(1'b0, 0);
    chk("midrst_fresh_done", 32'(load_done), 32'd1);
    if (log_q.size() == 1) begin
      chk("midrst_fresh_w", 32'({log_q[0].addr, log_q[0].data}), 32'h0020_BEEF);
    end

    // Random images: gap-free run, then gapped run, write sequences must match.
    for (int r = 0; r < 12; r++) begin
      stim_q.delete();
      origin = $urandom_range(0, 130);
      count  = $urandom_range(0, 5);
      stim_q.push_back(8'(origin >> 8)); stim_q.push_back(8'(origin));
      stim_q.push_back(8'(count >> 8));  stim_q.push_back(8'(count));
      x = 8'(origin >> 8) ^ 8'(origin) ^ 8'(count >> 8) ^ 8'(count);
      for (int i = 0; i < 2*count; i++) begin
        stim_q.push_back(8'($urandom));
        x = x ^ stim_q[stim_q.size() - 1];
      end
      stim_q.push_back(($urandom_range(0, 3) == 0) ? (x ^ 8'($urandom_range(1, 255))) : x);
      load(1'b1, 0);
      prev_q = log_q;
      load(1'b1, -1);
      chk("gap_n_writes", 32'(log_q.size()), 32'(prev_q.size()));
      if (log_q.size() == prev_q.size()) begin
        for (int i = 0; i < log_q.size(); i++) begin
          chk("gap_write", 32'(log_q[i]), 32'(prev_q[i]));
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
